// File: rtl/led_fb_pkg.sv
// Shared types and sizing for the double-buffered LED frame store.
package led_fb_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int PIXEL_W_DEF = 8;
  localparam int FB_DEPTH    = 2 ** (ADDR_W_DEF + 1);

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_CLEAR,
    FB_SWAP_WAIT
  } fb_state_t;

  function automatic int fb_depth(input int addr_w);
    return 2 ** (addr_w + 1);
  endfunction

endpackage

// File: rtl/led_fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
module led_fb_ram
  import led_fb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [PIXEL_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [PIXEL_W-1:0] rdata
);

  logic [PIXEL_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel store: scanner reads the front bank, producer fills the
// back bank, and the banks trade places only on the scanner's end-of-frame pulse.
module led_frame_buffer
  import led_fb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pixelAddress0,
  input  logic [ADDR_W-1:0]  pixelAddress1,
  output logic [PIXEL_W-1:0] pixel0,
  output logic [PIXEL_W-1:0] pixel1,
  input  logic               done,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W:0]    wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               swap_req,
  input  logic               clear_req,
  input  logic [PIXEL_W-1:0] clear_value,
  output logic               swap_ack,
  output logic               busy,
  output logic               front_sel
);

  localparam logic [ADDR_W:0] LAST_ENTRY = (ADDR_W + 1)'(fb_depth(ADDR_W) - 1);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);

  fb_state_t          state_q, state_d;
  logic               front_sel_q, front_sel_d;
  logic               swap_ack_q, swap_ack_d;
  logic               busy_q, busy_d;
  logic               wr_ready_q, wr_ready_d;
  logic [ADDR_W:0]    clr_cnt_q, clr_cnt_d;
  logic [PIXEL_W-1:0] clr_val_q, clr_val_d;

  logic               ram_we;
  logic [ADDR_W:0]    ram_addr;
  logic [PIXEL_W-1:0] ram_data;
  logic               back_sel;

  logic               front_sel_p1;
  logic               rd_vld_p1;
  logic [PIXEL_W-1:0] rd_data [2][2];

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swap_ack_d  = 1'b0;
    clr_cnt_d   = clr_cnt_q;
    clr_val_d   = clr_val_q;
    ram_we      = 1'b0;
    ram_addr    = wr_addr;
    ram_data    = wr_data;
    case (state_q)
      FB_IDLE: begin
        ram_we = wr_valid && wr_ready_q;
        // clear outranks a coincident swap request, which is then dropped
        if (clear_req) begin
          state_d   = FB_CLEAR;
          clr_val_d = clear_value;
          clr_cnt_d = '0;
        end else if (swap_req && done) begin
          front_sel_d = ~front_sel_q;
          swap_ack_d  = 1'b1;
        end else if (swap_req) begin
          state_d = FB_SWAP_WAIT;
        end
      end
      FB_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
        ram_data = clr_val_q;
        if (clr_cnt_q == LAST_ENTRY) begin
          state_d   = FB_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_ONE;
        end
      end
      FB_SWAP_WAIT: begin
        if (done) begin
          front_sel_d = ~front_sel_q;
          swap_ack_d  = 1'b1;
          state_d     = FB_IDLE;
        end
      end
      default: state_d = FB_IDLE;
    endcase
    busy_d     = (state_d != FB_IDLE);
    wr_ready_d = (state_d == FB_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FB_IDLE;
      front_sel_q  <= 1'b0;
      swap_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
      wr_ready_q   <= 1'b1;
      clr_cnt_q    <= '0;
      front_sel_p1 <= 1'b0;
      rd_vld_p1    <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      swap_ack_q   <= swap_ack_d;
      busy_q       <= busy_d;
      wr_ready_q   <= wr_ready_d;
      clr_cnt_q    <= clr_cnt_d;
      front_sel_p1 <= front_sel_q;
      rd_vld_p1    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    clr_val_q <= clr_val_d;
  end

  assign back_sel = ~front_sel_q;

  // stage p0 -> p1: addresses sampled into the RAM read registers alongside front_sel
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      led_fb_ram #(
        .ADDR_W (ADDR_W),
        .PIXEL_W(PIXEL_W)
      ) u_ram (
        .clk  (clk),
        .we   (ram_we && (back_sel == 1'(b)) && (ram_addr[ADDR_W] == 1'(h))),
        .waddr(ram_addr[ADDR_W-1:0]),
        .wdata(ram_data),
        .raddr((h == 0) ? pixelAddress0 : pixelAddress1),
        .rdata(rd_data[b][h])
      );
    end
  end

  // stage p1: output mux steered by the bank that was front when the address was taken
  assign pixel0    = rd_vld_p1 ? rd_data[front_sel_p1][0] : '0;
  assign pixel1    = rd_vld_p1 ? rd_data[front_sel_p1][1] : '0;
  assign wr_ready  = wr_ready_q;
  assign swap_ack  = swap_ack_q;
  assign busy      = busy_q;
  assign front_sel = front_sel_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomized self-checking bench for led_frame_buffer against a bank/array model.
module tb_led_frame_buffer;

  localparam int AW    = 11;
  localparam int PW    = 8;
  localparam int HALF  = 2 ** AW;
  localparam int DEPTH = 2 * HALF;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pixelAddress0, pixelAddress1;
  logic [PW-1:0] pixel0, pixel1;
  logic          done, wr_valid, wr_ready;
  logic [AW:0]   wr_addr;
  logic [PW-1:0] wr_data;
  logic          swap_req, clear_req;
  logic [PW-1:0] clear_value;
  logic          swap_ack, busy, front_sel;

  int errors = 0;
  int checks = 0;

  // model: full contents of both banks plus which one the scanner sees
  logic [PW-1:0] m_mem [2][DEPTH];
  int            m_front;

  always #5 clk = ~clk;

  led_frame_buffer #(.ADDR_W(AW), .PIXEL_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixelAddress0(pixelAddress0),
    .pixelAddress1(pixelAddress1),
    .pixel0       (pixel0),
    .pixel1       (pixel1),
    .done         (done),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .clear_req    (clear_req),
    .clear_value  (clear_value),
    .swap_ack     (swap_ack),
    .busy         (busy),
    .front_sel    (front_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    done = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    swap_req = 1'b0; clear_req = 1'b0; clear_value = '0;
  endtask

  task automatic do_write(input logic [AW:0] a, input logic [PW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
    m_mem[1-m_front][a] = d;
  endtask

  task automatic read12(input logic [AW:0] a, output logic [PW-1:0] v);
    pixelAddress0 = a[AW-1:0]; pixelAddress1 = a[AW-1:0];
    tick();
    v = a[AW] ? pixel1 : pixel0;
  endtask

  task automatic do_clear(input logic [PW-1:0] v, output int n, output int ready_seen);
    clear_req = 1'b1; clear_value = v;
    tick();
    clear_req = 1'b0; clear_value = PW'($urandom);
    n = 0; ready_seen = 0;
    while (busy === 1'b1 && n < DEPTH + 100) begin
      if (wr_ready !== 1'b0) ready_seen++;
      n++;
      tick();
    end
    for (int i = 0; i < DEPTH; i++) m_mem[1-m_front][i] = v;
  endtask

  task automatic do_swap(input int wait_cycles, output logic ack_on, output logic ack_after);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (wait_cycles) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    ack_on = swap_ack;
    m_front = 1 - m_front;
    tick();
    ack_after = swap_ack;
  endtask

  task automatic test_reset();
    idle_inputs();
    pixelAddress0 = '0; pixelAddress1 = '0;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (pixel0 !== 8'h00) begin errors++; $display("FAIL reset_pixel0 got=%h exp=00", pixel0); end
    checks++; if (pixel1 !== 8'h00) begin errors++; $display("FAIL reset_pixel1 got=%h exp=00", pixel1); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel got=%b exp=0", front_sel); end
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL reset_swap_ack got=%b exp=0", swap_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    rst = 1'b0;
    m_front = 0;
    tick();
  endtask

  task automatic test_clear();
    int n, rs;
    logic a_on, a_after;
    logic [AW:0] a;
    logic [PW-1:0] v, cv;
    do_clear(8'h00, n, rs);
    checks++; if (n != DEPTH) begin errors++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", n, DEPTH); end
    checks++; if (rs != 0) begin errors++; $display("FAIL clear_wr_ready_low got=%0d high cycles exp=0", rs); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clear_end_wr_ready got=%b exp=1", wr_ready); end
    do_swap(3, a_on, a_after);
    checks++; if (a_on !== 1'b1) begin errors++; $display("FAIL clear_swap_ack got=%b exp=1", a_on); end
    checks++; if (a_after !== 1'b0) begin errors++; $display("FAIL clear_swap_ack_width got=%b exp=0", a_after); end
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL clear_front_sel got=%b exp=1", front_sel); end
    for (int i = 0; i < 16; i++) begin
      a = (AW+1)'($urandom);
      read12(a, v);
      checks++; if (v !== m_mem[m_front][a]) begin errors++; $display("FAIL clear_read a=%h got=%h exp=%h", a, v, m_mem[m_front][a]); end
    end
    cv = PW'($urandom_range(1, 255));
    do_clear(cv, n, rs);
    checks++; if (n != DEPTH) begin errors++; $display("FAIL clear2_busy_cycles got=%0d exp=%0d", n, DEPTH); end
  endtask

  task automatic test_write_swap();
    logic [AW:0] addrs [16];
    logic [PW-1:0] v0, v1, v;
    logic a_on, a_after;
    for (int i = 0; i < 16; i++) begin
      addrs[i] = (AW+1)'($urandom);
      do_write(addrs[i], PW'($urandom));
    end
    do_write(12'h005, 8'h2A);
    do_write(12'h805, 8'h15);
    pixelAddress0 = 11'd5; pixelAddress1 = 11'd5;
    tick();
    v0 = pixel0; v1 = pixel1;
    checks++; if (v0 !== m_mem[m_front][5]) begin errors++; $display("FAIL preswap_pixel0 got=%h exp=%h", v0, m_mem[m_front][5]); end
    checks++; if (v1 !== m_mem[m_front][HALF+5]) begin errors++; $display("FAIL preswap_pixel1 got=%h exp=%h", v1, m_mem[m_front][HALF+5]); end
    do_swap(0, a_on, a_after);
    checks++; if (a_on !== 1'b1) begin errors++; $display("FAIL ws_swap_ack got=%b exp=1", a_on); end
    pixelAddress0 = 11'd5; pixelAddress1 = 11'd5;
    tick();
    checks++; if (pixel0 !== 8'h2A) begin errors++; $display("FAIL postswap_pixel0 got=%h exp=2a", pixel0); end
    checks++; if (pixel1 !== 8'h15) begin errors++; $display("FAIL postswap_pixel1 got=%h exp=15", pixel1); end
    for (int i = 0; i < 16; i++) begin
      read12(addrs[i], v);
      checks++; if (v !== m_mem[m_front][addrs[i]]) begin errors++; $display("FAIL ws_read a=%h got=%h exp=%h", addrs[i], v, m_mem[m_front][addrs[i]]); end
    end
  endtask

  task automatic test_swap_wait();
    logic [AW:0] a;
    logic [PW-1:0] d, v;
    int bad;
    a = (AW+1)'($urandom);
    d = PW'($urandom);
    while (d == m_mem[0][a] || d == m_mem[1][a]) d = d + 8'd1;
    pixelAddress0 = a[AW-1:0]; pixelAddress1 = a[AW-1:0];
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      v = a[AW] ? pixel1 : pixel0;
      if (busy !== 1'b1 || wr_ready !== 1'b0 || swap_ack !== 1'b0 || front_sel !== 1'(m_front)) bad++;
      if (i > 0 && v !== m_mem[m_front][a]) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wait_stall bad_cycles=%0d exp=0", bad); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (swap_ack !== 1'b1) begin errors++; $display("FAIL wait_swap_ack got=%b exp=1", swap_ack); end
    checks++; if (front_sel !== 1'(1 - m_front)) begin errors++; $display("FAIL wait_front_sel got=%b exp=%0d", front_sel, 1 - m_front); end
    m_front = 1 - m_front;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wait_ready_after got=%b exp=1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    m_mem[1-m_front][a] = d;
    read12(a, v);
    checks++; if (v !== m_mem[m_front][a]) begin errors++; $display("FAIL wait_no_ram_change got=%h exp=%h", v, m_mem[m_front][a]); end
    swap_req = 1'b1; done = 1'b1;
    tick();
    swap_req = 1'b0; done = 1'b0;
    m_front = 1 - m_front;
    read12(a, v);
    checks++; if (v !== d) begin errors++; $display("FAIL wait_stalled_write got=%h exp=%h", v, d); end
  endtask

  task automatic test_swap_immediate();
    logic [AW:0] a;
    logic [PW-1:0] d, v;
    a = (AW+1)'($urandom);
    d = PW'($urandom);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    swap_req = 1'b1; done = 1'b1;
    tick();
    wr_valid = 1'b0; swap_req = 1'b0; done = 1'b0;
    m_mem[1-m_front][a] = d;
    m_front = 1 - m_front;
    checks++; if (swap_ack !== 1'b1) begin errors++; $display("FAIL imm_swap_ack got=%b exp=1", swap_ack); end
    checks++; if (front_sel !== 1'(m_front)) begin errors++; $display("FAIL imm_front_sel got=%b exp=%0d", front_sel, m_front); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL imm_busy got=%b exp=0", busy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL imm_wr_ready got=%b exp=1", wr_ready); end
    read12(a, v);
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL imm_ack_width got=%b exp=0", swap_ack); end
    checks++; if (v !== d) begin errors++; $display("FAIL imm_write_visible got=%h exp=%h", v, d); end
  endtask

  task automatic test_read_on_swap();
    logic [PW-1:0] old0, old1;
    do_write(12'h007, m_mem[m_front][7] ^ 8'h5A);
    do_write(12'h807, m_mem[m_front][HALF+7] ^ 8'hA5);
    old0 = m_mem[m_front][7];
    old1 = m_mem[m_front][HALF+7];
    pixelAddress0 = 11'd7; pixelAddress1 = 11'd7;
    swap_req = 1'b1; done = 1'b1;
    tick();
    swap_req = 1'b0; done = 1'b0;
    checks++; if (pixel0 !== old0) begin errors++; $display("FAIL ros_old_pixel0 got=%h exp=%h", pixel0, old0); end
    checks++; if (pixel1 !== old1) begin errors++; $display("FAIL ros_old_pixel1 got=%h exp=%h", pixel1, old1); end
    m_front = 1 - m_front;
    tick();
    checks++; if (pixel0 !== m_mem[m_front][7]) begin errors++; $display("FAIL ros_new_pixel0 got=%h exp=%h", pixel0, m_mem[m_front][7]); end
    checks++; if (pixel1 !== m_mem[m_front][HALF+7]) begin errors++; $display("FAIL ros_new_pixel1 got=%h exp=%h", pixel1, m_mem[m_front][HALF+7]); end
  endtask

  task automatic test_ignored();
    logic [PW-1:0] cv, v;
    logic [AW:0] a;
    logic a_on, a_after;
    int n, bad;
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL lone_done_ack got=%b exp=0", swap_ack); end
    checks++; if (front_sel !== 1'(m_front)) begin errors++; $display("FAIL lone_done_front got=%b exp=%0d", front_sel, m_front); end
    cv = PW'($urandom);
    clear_req = 1'b1; swap_req = 1'b1; clear_value = cv;
    tick();
    n = 0; bad = 0;
    while (busy === 1'b1 && n < DEPTH + 100) begin
      swap_req    = (n < 8);
      done        = (n >= 2 && n < 10);
      clear_req   = (n >= 4 && n < 12);
      clear_value = ~cv;
      if (front_sel !== 1'(m_front) || swap_ack !== 1'b0) bad++;
      n++;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) m_mem[1-m_front][i] = cv;
    checks++; if (n != DEPTH) begin errors++; $display("FAIL ign_clear_cycles got=%0d exp=%0d", n, DEPTH); end
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_during_clear bad_cycles=%0d exp=0", bad); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL ign_dropped_swap got=%b exp=0", swap_ack); end
    do_swap(2, a_on, a_after);
    for (int i = 0; i < 8; i++) begin
      a = (AW+1)'($urandom);
      read12(a, v);
      checks++; if (v !== m_mem[m_front][a]) begin errors++; $display("FAIL ign_fill a=%h got=%h exp=%h", a, v, m_mem[m_front][a]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic a_on, a_after;
    if (m_front == 0) do_swap(1, a_on, a_after);
    checks++; if (front_sel !== 1'b1) begin errors++; $display("FAIL rmc_pre_front got=%b exp=1", front_sel); end
    clear_req = 1'b1; clear_value = 8'hC3;
    tick();
    clear_req = 1'b0;
    repeat (1000) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmc_pre_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #2;
    checks++; if (pixel0 !== 8'h00) begin errors++; $display("FAIL rmc_pixel0 got=%h exp=00", pixel0); end
    checks++; if (pixel1 !== 8'h00) begin errors++; $display("FAIL rmc_pixel1 got=%h exp=00", pixel1); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL rmc_front_sel got=%b exp=0", front_sel); end
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL rmc_swap_ack got=%b exp=0", swap_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy got=%b exp=0", busy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmc_wr_ready got=%b exp=1", wr_ready); end
    tick();
    rst = 1'b0;
    m_front = 0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_post_busy got=%b exp=0", busy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmc_post_wr_ready got=%b exp=1", wr_ready); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL rmc_post_done_ack got=%b exp=0", swap_ack); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_write_swap();
    test_swap_wait();
    test_swap_immediate();
    test_read_on_swap();
    test_ignored();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
